// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester handshakes and SRAM strobes of the memory bus arbiter
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
    logic [ADDR_W-1:0] ADDR;
    logic              Mem_CE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic              Mem_OE;
    logic              Mem_WE;
    logic              busy;
    logic              grant_dbg;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        output ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy, grant_dbg
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        input  ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy, grant_dbg
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin CPU/debug arbiter sequencing one SRAM word access at a time
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_bus_arbiter_if.slave   bus,
    inout  wire [DATA_W-1:0]   Data
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_gnt_dbg;
    logic              r_rr_dbg;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              w_any_req;
    logic              w_pick_dbg;
    logic              w_access_end;
    logic              w_drive;

    // r_rr_dbg set means the debug port wins the next tie
    assign w_any_req    = bus.cpu_req | bus.dbg_req;
    assign w_pick_dbg   = bus.dbg_req & (~bus.cpu_req | r_rr_dbg);
    assign w_access_end = (r_state == ACCESS) && (r_cnt == LAST_CNT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.Mem_CE   = 1'b1;
        bus.Mem_UB   = 1'b1;
        bus.Mem_LB   = 1'b1;
        bus.Mem_OE   = 1'b1;
        bus.Mem_WE   = 1'b1;
        bus.cpu_ack  = 1'b0;
        bus.dbg_ack  = 1'b0;
        w_drive      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_next = SETUP;
            end
            SETUP: begin
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = r_we;
                w_drive    = r_we;
                w_next     = ACCESS;
            end
            ACCESS: begin
                bus.Mem_CE = 1'b0;
                bus.Mem_UB = 1'b0;
                bus.Mem_LB = 1'b0;
                bus.Mem_OE = r_we;
                bus.Mem_WE = ~r_we;
                w_drive    = r_we;
                if (r_cnt == LAST_CNT) w_next = DONE;
            end
            DONE: begin
                // data held one extra cycle after WE rises for SRAM hold time
                bus.Mem_CE  = 1'b0;
                bus.Mem_UB  = 1'b0;
                bus.Mem_LB  = 1'b0;
                w_drive     = r_we;
                bus.cpu_ack = ~r_gnt_dbg;
                bus.dbg_ack = r_gnt_dbg;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_gnt_dbg   <= 1'b0;
            r_rr_dbg    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_we      <= w_pick_dbg ? bus.dbg_we    : bus.cpu_we;
                r_addr    <= w_pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                r_wdata   <= w_pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                r_gnt_dbg <= w_pick_dbg;
                r_rr_dbg  <= ~w_pick_dbg;
            end
            r_cnt <= (r_state == ACCESS) ? r_cnt + 4'd1 : 4'd0;
            if (w_access_end && !r_we) begin
                if (r_gnt_dbg) r_dbg_rdata <= Data;
                else           r_cpu_rdata <= Data;
            end
        end
    end

    assign Data          = w_drive ? r_wdata : 'z;
    assign bus.ADDR      = r_addr;
    assign bus.busy      = (r_state != IDLE);
    assign bus.grant_dbg = r_gnt_dbg;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dbg_rdata = r_dbg_rdata;
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences every access to the shared external 16-bit SRAM: ADDR, tristate Data, and the active-low Mem_CE/UB/LB/OE/WE strobes.
- Arbitrates between two requesters: the CPU datapath (MAR/MDR side) and the debug/loader port (switch-driven memory inspect/load).
- Performs one word transaction at a time with a programmable number of wait cycles.
- Returns read data and a single-cycle acknowledge to the requester that was granted.

Parameters:
- WAIT_CYCLES, 1, cycles spent in ACCESS per transaction; legal range 1..15.
- ADDR_W, 20, memory address width.
- DATA_W, 16, memory data width.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU requests a transaction; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered CPU read data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: debug-port equivalents, same widths and rules as the CPU signals.
- ADDR  out  ADDR_W  SRAM address.
- Data  inout  DATA_W  SRAM data bus.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.
- busy  out  1  high in every state except IDLE.
- grant_dbg  out  1  current or most recent grant went to the debug port.

Behaviour:
- States: IDLE, SETUP, ACCESS, DONE. A 4-bit wait counter runs in ACCESS.
- IDLE:
  - All strobes high, Data = Z, ADDR holds its last value.
  - At each edge, sample cpu_req and dbg_req.
  - One requester asserted: grant it.
  - Both asserted: grant the one not granted last (round-robin).
  - Grant latches the winner's we, addr and wdata into internal registers, updates grant_dbg, and moves to SETUP.
- SETUP (1 cycle):
  - ADDR = latched addr; Mem_CE = Mem_UB = Mem_LB = 0.
  - Read: Mem_OE = 0. Write: Mem_OE = 1, Mem_WE = 1, Data driven with latched wdata.
- ACCESS (WAIT_CYCLES cycles):
  - CE, UB and LB stay low.
  - Read: OE stays 0, Data = Z.
  - Write: Mem_WE = 0, Data driven.
  - Counter loads 0 on entry; exit to DONE at the edge where counter == WAIT_CYCLES-1.
  - For reads, Data is captured into the granted requester's rdata register on that same exit edge.
- DONE (1 cycle):
  - Mem_WE = 1, Mem_OE = 1; CE, UB and LB stay low.
  - Write: Data still driven (hold time).
  - Granted requester's ack = 1; the other ack stays 0.
  - Next edge: go to IDLE. No back-to-back grant from DONE.
- Latency:
  - Request sampled at edge E.
  - ack high during the cycle after edge E+1+WAIT_CYCLES.
  - Bus free, with the next grant possible, at edge E+3+WAIT_CYCLES.
- Handshake:
  - A requester keeps req and its operands stable until ack.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
  - Operands are latched at grant, so later changes have no effect on the transaction in flight.
  - req dropped mid-transaction: the transaction still completes and ack still pulses.
- rdata registers change only on the owner's read completion; writes leave them unchanged.
- Data bus is driven only during SETUP, ACCESS and DONE of a write; Z at all other times, including during reset.
- Reset asserted (Reset = 0), at any time including mid-transaction:
  - Immediately: state IDLE, all strobes 1, Data Z.
  - ADDR = 0; cpu_rdata = dbg_rdata = 0.
  - Both acks 0; busy 0; grant_dbg 0.
  - Round-robin pointer set so the CPU wins the first tie.
  - A write interrupted by reset is abandoned with no ack.

Test Plan:
- CPU read, WAIT_CYCLES=1, cpu_addr=0x00010, SRAM model holds 0x1234 -> CE low from SETUP; OE low in SETUP and ACCESS; WE never low; cpu_ack pulses exactly 3 cycles after the sampling edge; cpu_rdata=0x1234; dbg_rdata unchanged at 0.
- Debug write, dbg_addr=0x0ABCD, dbg_wdata=0xBEEF -> WE low exactly WAIT_CYCLES cycles; Data=0xBEEF from SETUP through DONE; model location updated; dbg_ack one pulse; grant_dbg=1; readback returns 0xBEEF.
- Simultaneous cpu_req and dbg_req, both held, 4 transactions after reset -> grant order CPU, DBG, CPU, DBG; never two acks in one cycle.
- WAIT_CYCLES=3 read -> ACCESS lasts exactly 3 cycles; ack 5 cycles after the sampling edge; busy high for 5 cycles.
- Reset pulsed low in ACCESS of a CPU write to 0x00020 -> all strobes 1 and Data Z asynchronously; no cpu_ack; next tie after release goes to CPU.
- cpu_req dropped in SETUP -> transaction completes, cpu_ack still pulses; with cpu_req held one extra cycle after ack, a second transaction starts.
